// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding, write-buffer entry type and helpers for dmem_responder
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] idx;
        logic [31:0]            data;
    } wb_entry_t;

    // Slot k positions after head in a ring of n entries.
    function automatic int slot_of(input int head, input int k, input int n);
        return (head + k >= n) ? head + k - n : head + k;
    endfunction

endpackage

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-store FIFO with a youngest-match lookup for load forwarding
module dmem_write_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push,
    input  logic [DMEM_ADDR_W-1:0] push_idx,
    input  logic [31:0]            push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [DMEM_ADDR_W-1:0] head_idx,
    output logic [31:0]            head_data,
    input  logic [DMEM_ADDR_W-1:0] lookup_idx,
    output logic                   hit,
    output logic [31:0]            hit_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_idx  = mem[rd_ptr].idx;
    assign head_data = mem[rd_ptr].data;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= '{idx: push_idx, data: push_data};
    end

    // Walk from oldest to youngest so the last match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count) && mem[PW'(slot_of(int'(rd_ptr), k, DEPTH))].idx == lookup_idx) begin
                hit      = 1'b1;
                hit_data = mem[PW'(slot_of(int'(rd_ptr), k, DEPTH))].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with posted stores, forwarding and fixed-latency loads
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int LAT      = 3,
    parameter int WB_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        idle_o
);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] idx, rd_idx, head_idx;
    logic [31:0]       rd_word, head_data, hit_data;
    logic [31:0]       mem [2**ADDR_W];
    logic              in_idle, oor, st_req, ld_req, push, pop, launch, rd_last, rd_go;
    logic              wb_full, wb_empty, wb_hit, unused;

    assign idx     = addr_i[ADDR_W+1:2];
    assign oor     = |addr_i[31:ADDR_W+2];
    assign unused  = ^addr_i[1:0];
    assign in_idle = state == IDLE;
    assign st_req  = in_idle & MemWrite_i & ~oor;
    assign ld_req  = in_idle & MemRead_i & ~MemWrite_i & ~oor;
    assign push    = st_req & ~wb_full;
    assign launch  = ld_req & ~wb_hit;
    // The array port belongs to the read from launch until the response.
    assign pop     = in_idle & ~wb_empty & ~launch & rst_n_i;
    assign rd_last = (state == RD_WAIT) && (cnt == CNT_W'(1));
    assign rd_go   = rd_last | (launch & (LAT == 1));

    dmem_write_buffer #(.DEPTH(WB_DEPTH)) u_wb (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push       (push),
        .push_idx   (idx),
        .push_data  (data_i),
        .pop        (pop),
        .full       (wb_full),
        .empty      (wb_empty),
        .head_idx   (head_idx),
        .head_data  (head_data),
        .lookup_idx (idx),
        .hit        (wb_hit),
        .hit_data   (hit_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = in_idle            ? (launch ? ((LAT == 1) ? RD_DONE : RD_WAIT) : IDLE) :
                   (state == RD_WAIT) ? (rd_last ? RD_DONE : RD_WAIT) :
                                        IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt <= '0;
        else cnt <= launch ? CNT_W'(LAT - 1) : (state == RD_WAIT) ? cnt - 1'b1 : cnt;
    end

    always_ff @(posedge clk_i) begin
        if (launch) rd_idx <= idx;
        if (pop) mem[head_idx] <= head_data;
        if (rd_go) rd_word <= mem[in_idle ? idx : rd_idx];
    end

    always_comb begin
        stall_o = (in_idle & ((st_req & wb_full) | launch)) | (state == RD_WAIT);
        err_o   = in_idle & (MemRead_i | MemWrite_i) & (oor | (MemRead_i & MemWrite_i));
        data_o  = (state == RD_DONE) ? rd_word : (ld_req & wb_hit) ? hit_data : '0;
        idle_o  = in_idle & wb_empty;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder (LAT=3/DEPTH=2 and LAT=1/DEPTH=1 instances)
module tb_dmem_responder;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr = '0, wdata = '0, addr1 = '0, wdata1 = '0;
    logic [31:0] data, data1;
    logic        stall, err, idle, stall1, err1, idle1;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .LAT(3), .WB_DEPTH(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .MemRead_i(rd), .MemWrite_i(wr), .addr_i(addr),
        .data_i(wdata), .data_o(data), .stall_o(stall), .err_o(err), .idle_o(idle)
    );

    dmem_responder #(.ADDR_W(8), .LAT(1), .WB_DEPTH(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1), .addr_i(addr1),
        .data_i(wdata1), .data_o(data1), .stall_o(stall1), .err_o(err1), .idle_o(idle1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        #1;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
        #1;
    endtask

    // Load miss on the LAT=3 instance: three stall cycles, then the response.
    task automatic miss(input string tag, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, '0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_stall%0d", tag, i), {31'b0, stall}, 32'd1);
            check($sformatf("%s_zero%0d", tag, i), data, 32'd0);
            tick;
        end
        check({tag, "_done"}, {31'b0, stall}, 32'd0);
        check({tag, "_data"}, data, exp);
        tick;
        drive(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick;
        tick;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_idle", {31'b0, idle}, 32'd1);
        rst_n = 1'b1;

        drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        check("st_stall", {31'b0, stall}, 32'd0);
        tick;
        drive(1'b0, 1'b0, '0, '0);
        check("wb_pending_idle", {31'b0, idle}, 32'd0);
        tick;
        check("drained_idle", {31'b0, idle}, 32'd1);
        miss("miss10", 32'h10, 32'hDEADBEEF);
        check("post_rd_idle", {31'b0, idle}, 32'd1);
        check("post_rd_data", data, 32'd0);

        drive(1'b0, 1'b1, 32'h20, 32'h11);
        check("st11_stall", {31'b0, stall}, 32'd0);
        tick;
        drive(1'b0, 1'b1, 32'h20, 32'h22);
        check("st22_stall", {31'b0, stall}, 32'd0);
        tick;
        drive(1'b1, 1'b0, 32'h20, '0);
        check("fwd_stall", {31'b0, stall}, 32'd0);
        check("fwd_data", data, 32'h22);
        tick;
        drive(1'b0, 1'b0, '0, '0);
        tick;
        miss("arr20", 32'h20, 32'h22);

        drive(1'b1, 1'b0, 32'h400, '0);
        check("oor_ld_err", {31'b0, err}, 32'd1);
        check("oor_ld_stall", {31'b0, stall}, 32'd0);
        check("oor_ld_data", data, 32'd0);
        tick;
        drive(1'b0, 1'b0, '0, '0);
        check("oor_err_pulse", {31'b0, err}, 32'd0);
        check("oor_idle", {31'b0, idle}, 32'd1);
        drive(1'b0, 1'b1, 32'h800, 32'h99);
        check("oor_st_err", {31'b0, err}, 32'd1);
        check("oor_st_stall", {31'b0, stall}, 32'd0);
        tick;
        drive(1'b0, 1'b0, '0, '0);
        check("oor_st_nopush", {31'b0, idle}, 32'd1);

        drive(1'b1, 1'b1, 32'h30, 32'h5A);
        check("both_err", {31'b0, err}, 32'd1);
        check("both_stall", {31'b0, stall}, 32'd0);
        tick;
        drive(1'b1, 1'b0, 32'h30, '0);
        check("both_fwd_err", {31'b0, err}, 32'd0);
        check("both_fwd_data", data, 32'h5A);
        tick;
        drive(1'b0, 1'b0, '0, '0);
        tick;
        miss("both_arr", 32'h30, 32'h5A);

        drive(1'b0, 1'b1, 32'h40, 32'h1234);
        tick;
        drive(1'b0, 1'b0, '0, '0);
        tick;
        drive(1'b0, 1'b1, 32'h40, 32'h77);
        tick;
        drive(1'b1, 1'b0, 32'h44, '0);
        check("rr_launch_stall", {31'b0, stall}, 32'd1);
        check("rr_launch_idle", {31'b0, idle}, 32'd0);
        tick;
        tick;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        check("rr_wait2_stall", {31'b0, stall}, 32'd1);
        tick;
        rst_n = 1'b1;
        check("rr_stall", {31'b0, stall}, 32'd0);
        check("rr_idle", {31'b0, idle}, 32'd1);
        miss("rr_discard", 32'h40, 32'h1234);

        drive1(1'b0, 1'b1, 32'h0, 32'hA1);
        check("d1_st0_stall", {31'b0, stall1}, 32'd0);
        tick;
        drive1(1'b0, 1'b1, 32'h4, 32'hB2);
        check("d1_full_stall", {31'b0, stall1}, 32'd1);
        tick;
        check("d1_st1_stall", {31'b0, stall1}, 32'd0);
        tick;
        drive1(1'b0, 1'b1, 32'h8, 32'hC3);
        check("d1_full2_stall", {31'b0, stall1}, 32'd1);
        tick;
        check("d1_st2_stall", {31'b0, stall1}, 32'd0);
        tick;
        drive1(1'b0, 1'b0, '0, '0);
        tick;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_w [3];
            exp_w = '{32'hA1, 32'hB2, 32'hC3};
            drive1(1'b1, 1'b0, 32'(i * 4), '0);
            check($sformatf("d1_ld%0d_stall", i), {31'b0, stall1}, 32'd1);
            tick;
            check($sformatf("d1_ld%0d_done", i), {31'b0, stall1}, 32'd0);
            check($sformatf("d1_ld%0d_data", i), data1, exp_w[i]);
            tick;
        end
        drive1(1'b0, 1'b0, '0, '0);
        check("d1_end_idle", {31'b0, idle1}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
